// File: rtl/uart_rx.sv
// UART receiver on the RIB slave bus: 2-flop synchroniser, 8N1 deframer,
// small receive FIFO drained through memory-mapped registers, level interrupt.
module uart_rx #(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_RESET  = 434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ack_o,
    input  logic        rx_pin,
    output logic        int_sig_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t         state, state_nx;
    logic [15:0]    cnt, cnt_nx;
    logic [2:0]     bit_idx, bit_idx_nx;
    logic [7:0]     shreg, shreg_nx;
    logic           brk, brk_nx;
    logic           push, frame_set;

    logic           sync1, rx_s;
    logic           rx_en, irq_en, overrun, frame_err;
    logic [15:0]    div;

    logic [7:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic           empty, full, pop, push_ok, ovr_set;

    logic           wr, rd, rd_data, rd_data_q;
    logic [3:0]     addr;
    logic [7:0]     head;
    logic [31:0]    count_ext;
    logic [3:0]     count_field;
    logic           unused_bits;

    assign unused_bits = ^{addr_i[31:4], data_i[31:16]};

    assign addr    = addr_i[3:0];
    assign wr      = req_i & we_i;
    assign rd      = req_i & ~we_i;
    assign rd_data = rd & (addr == 4'hC);
    assign ack_o   = req_i;

    assign empty   = (count == '0);
    assign full    = (count == CW'(FIFO_DEPTH));
    // Only the first cycle of a DATA read pops, so a held request drains one byte.
    assign pop     = rd_data & ~rd_data_q & ~empty;
    assign push_ok = push & (~full | pop);
    assign ovr_set = push & full & ~pop;
    assign head    = empty ? 8'h00 : mem[rd_ptr];

    assign count_ext   = 32'(count);
    assign count_field = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= rx_pin;
            rx_s  <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            brk     <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            bit_idx <= bit_idx_nx;
            shreg   <= shreg_nx;
            brk     <= brk_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        bit_idx_nx = bit_idx;
        shreg_nx   = shreg;
        brk_nx     = brk;
        push       = 1'b0;
        frame_set  = 1'b0;
        if (!rx_en) begin
            state_nx = IDLE;
            brk_nx   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state_nx = START;
                        cnt_nx   = div >> 1;
                    end
                end
                START: begin
                    if (cnt != '0) begin
                        cnt_nx = cnt - 16'd1;
                    end else if (rx_s) begin
                        state_nx = IDLE;
                    end else begin
                        state_nx   = DATA;
                        cnt_nx     = div - 16'd1;
                        bit_idx_nx = '0;
                    end
                end
                DATA: begin
                    if (cnt != '0) begin
                        cnt_nx = cnt - 16'd1;
                    end else begin
                        shreg_nx   = {rx_s, shreg[7:1]};
                        cnt_nx     = div - 16'd1;
                        bit_idx_nx = bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state_nx = STOP;
                    end
                end
                STOP: begin
                    // brk marks a framing error: the line must return high before re-arming.
                    if (cnt != '0) begin
                        cnt_nx = cnt - 16'd1;
                    end else if (brk) begin
                        if (rx_s) begin
                            state_nx = IDLE;
                            brk_nx   = 1'b0;
                        end
                    end else if (rx_s) begin
                        push     = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        frame_set = 1'b1;
                        brk_nx    = 1'b1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_en     <= 1'b0;
            irq_en    <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            div       <= 16'(DIV_RESET);
            rd_data_q <= 1'b0;
            int_sig_o <= 1'b0;
        end else begin
            rd_data_q <= rd_data;
            if (wr && addr == 4'h0) begin
                rx_en  <= data_i[0];
                irq_en <= data_i[1];
            end
            if (wr && addr == 4'h8)
                div <= (data_i[15:0] < 16'd4) ? 16'd4 : data_i[15:0];
            // A same-cycle set beats the write-1-to-clear.
            overrun   <= (overrun   & ~(wr && addr == 4'h4 && data_i[1])) | ovr_set;
            frame_err <= (frame_err & ~(wr && addr == 4'h4 && data_i[2])) | frame_set;
            int_sig_o <= irq_en & (~empty | overrun | frame_err);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= shreg;
    end

    always_comb begin
        data_o = '0;
        if (rd) begin
            case (addr)
                4'h0:    data_o = {30'd0, irq_en, rx_en};
                4'h4:    data_o = {24'd0, count_field, 1'b0, frame_err, overrun, ~empty};
                4'h8:    data_o = {16'd0, div};
                4'hC:    data_o = {24'd0, head};
                default: data_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: register access, framing, FIFO overrun, errors and interrupt.
module tb_uart_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] data_i = '0;
    logic [31:0] data_o;
    logic        ack_o;
    logic        rx_pin = 1'b1;
    logic        int_sig_o;

    int tests = 0;
    int fails = 0;
    logic [31:0] d;

    always #5 clk = ~clk;

    uart_rx dut (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req_i),
        .we_i      (we_i),
        .addr_i    (addr_i),
        .data_i    (data_i),
        .data_o    (data_o),
        .ack_o     (ack_o),
        .rx_pin    (rx_pin),
        .int_sig_o (int_sig_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] v);
        @(negedge clk);
        req_i = 1'b1; we_i = 1'b1; addr_i = {28'd0, a}; data_i = v;
        @(posedge clk);
        #1 req_i = 1'b0; we_i = 1'b0; data_i = '0;
    endtask

    // Idle cycle at the end lets the pop edge detector settle between reads.
    task automatic bus_read(input logic [3:0] a, output logic [31:0] v);
        @(negedge clk);
        req_i = 1'b1; we_i = 1'b0; addr_i = {28'd0, a};
        #1 v = data_o;
        @(posedge clk);
        #1 req_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic rd_check(input string tag, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] v;
        bus_read(a, v);
        check(tag, v, exp);
    endtask

    // Leaves rx_pin at the stop level so a low stop bit can be extended by the caller.
    task automatic send_frame(input logic [7:0] b, input int div, input logic stop);
        @(negedge clk);
        rx_pin = 1'b0;
        repeat (div) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_pin = b[i];
            repeat (div) @(negedge clk);
        end
        rx_pin = stop;
        repeat (div) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset mid-frame with two bytes buffered
        bus_write(4'h8, 32'd16);
        bus_write(4'h0, 32'h3);
        send_frame(8'hAA, 16, 1'b1);
        repeat (4) @(negedge clk);
        send_frame(8'h55, 16, 1'b1);
        repeat (4) @(negedge clk);
        rd_check("pre_reset_status", 4'h4, 32'h21);
        check("pre_reset_int", {31'd0, int_sig_o}, 32'd1);
        fork
            send_frame(8'h99, 16, 1'b1);
            begin
                repeat (50) @(negedge clk);
                rst = 1'b0;
                #1 check("reset_int_async", {31'd0, int_sig_o}, 32'd0);
                repeat (3) @(negedge clk);
                rst = 1'b1;
            end
        join
        repeat (4) @(negedge clk);
        rd_check("reset_status", 4'h4, 32'h0);
        rd_check("reset_ctrl", 4'h0, 32'h0);
        rd_check("reset_div", 4'h8, 32'd434);
        rd_check("reset_data", 4'hC, 32'h0);
        check("reset_int", {31'd0, int_sig_o}, 32'd0);

        // Divider clamp and single frame
        bus_write(4'h8, 32'd3);
        rd_check("div_clamp", 4'h8, 32'd4);
        bus_write(4'h8, 32'd16);
        rd_check("div_16", 4'h8, 32'd16);
        bus_write(4'h0, 32'h1);
        send_frame(8'hA5, 16, 1'b1);
        repeat (4) @(negedge clk);
        @(negedge clk);
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h4;
        #1 check("ack", {31'd0, ack_o}, 32'd1);
        check("single_status", data_o, 32'h11);
        @(posedge clk);
        #1 req_i = 1'b0;
        @(posedge clk);
        #1 check("ack_idle", {31'd0, ack_o}, 32'd0);
        rd_check("single_data", 4'hC, 32'hA5);
        rd_check("single_after", 4'h4, 32'h0);

        // Overrun: five bytes into a four-entry FIFO
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 16, 1'b1);
            repeat (4) @(negedge clk);
        end
        rd_check("ovr_status", 4'h4, 32'h43);
        rd_check("ovr_data1", 4'hC, 32'h01);
        rd_check("ovr_data2", 4'hC, 32'h02);
        rd_check("ovr_data3", 4'hC, 32'h03);
        rd_check("ovr_data4", 4'hC, 32'h04);
        rd_check("ovr_drained", 4'h4, 32'h02);
        bus_write(4'h4, 32'h2);
        rd_check("ovr_cleared", 4'h4, 32'h0);

        // Framing error, line held low, then recovery
        send_frame(8'h3C, 16, 1'b0);
        repeat (40) @(negedge clk);
        rx_pin = 1'b1;
        repeat (5) @(negedge clk);
        rd_check("ferr_status", 4'h4, 32'h04);
        send_frame(8'h7E, 16, 1'b1);
        repeat (4) @(negedge clk);
        rd_check("ferr_next_status", 4'h4, 32'h15);
        rd_check("ferr_next_data", 4'hC, 32'h7E);
        bus_write(4'h4, 32'h4);
        rd_check("ferr_cleared", 4'h4, 32'h0);

        // Glitch rejection, then interrupt assert/deassert
        @(negedge clk);
        rx_pin = 1'b0;
        repeat (3) @(negedge clk);
        rx_pin = 1'b1;
        repeat (40) @(negedge clk);
        rd_check("glitch_status", 4'h4, 32'h0);
        bus_write(4'h0, 32'h3);
        repeat (2) @(posedge clk);
        #1 check("irq_idle", {31'd0, int_sig_o}, 32'd0);
        send_frame(8'h11, 16, 1'b1);
        repeat (3) @(posedge clk);
        #1 check("irq_set", {31'd0, int_sig_o}, 32'd1);
        @(negedge clk);
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'hC;
        #1 check("irq_data", data_o, 32'h11);
        @(posedge clk);
        #1 req_i = 1'b0;
        check("irq_latency", {31'd0, int_sig_o}, 32'd1);
        @(posedge clk);
        #1 check("irq_clear", {31'd0, int_sig_o}, 32'd0);
        @(posedge clk);
        #1;

        // Push and pop on the same edge with the FIFO full
        bus_write(4'h0, 32'h1);
        send_frame(8'h10, 16, 1'b1);
        repeat (4) @(negedge clk);
        send_frame(8'h20, 16, 1'b1);
        repeat (4) @(negedge clk);
        send_frame(8'h30, 16, 1'b1);
        repeat (4) @(negedge clk);
        send_frame(8'h40, 16, 1'b1);
        repeat (4) @(negedge clk);
        rd_check("full_status", 4'h4, 32'h41);
        fork
            send_frame(8'h50, 16, 1'b1);
            begin
                // Stop-bit sample lands on the 156th posedge after the start edge.
                @(negedge clk);
                repeat (155) @(negedge clk);
                req_i = 1'b1; we_i = 1'b0; addr_i = 32'hC;
                #1 d = data_o;
                @(posedge clk);
                #1 req_i = 1'b0;
            end
        join
        check("simul_data", d, 32'h10);
        repeat (3) @(posedge clk);
        #1;
        rd_check("simul_status", 4'h4, 32'h41);
        rd_check("simul_data2", 4'hC, 32'h20);
        rd_check("simul_data3", 4'hC, 32'h30);
        rd_check("simul_data4", 4'hC, 32'h40);
        rd_check("simul_data5", 4'hC, 32'h50);
        rd_check("simul_empty", 4'h4, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
